mc_control: RTL and testbench

Multicycle control FSM for the MIPS core: the sequencer that drives the shared PC/IR/ALU/memory datapath one phase per clock, replacing the per-instruction combinational control of the single-cycle design. It sits between the instruction register (opcode), the ALU zero flag and the unified memory (ready handshake). It produces every datapath enable and mux select, including the PC-update enable that the fetch path consumes.

---
 rtl/mc_pkg.sv | 57 +++++
 rtl/mc_outputs.sv | 71 +++++++
 rtl/mc_control.sv | 90 +++++++++
 tb/tb_mc_control.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control sequencer.
// Imported by the output decoder and by the top-level FSM.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/mc_outputs.sv
// Combinational state -> control-vector decoder. Moore outputs, except that
// the FETCH enables follow mem_ready and the BRANCH pc_en follows zero.
module mc_outputs
  import mc_pkg::*;
(
  input  logic [3:0] state,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state_t'(state))
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
        ctrl.pc_en     = zero;
      end
      S_JUMP: begin
        ctrl.pc_en     = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_ADDI_WB: ctrl.reg_write = 1'b1;
      S_TRAP:    ctrl.halted    = 1'b1;
      default:   ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: state register, next-state logic and reset
// gating of the enables produced by mc_outputs.
module mc_control
  import mc_pkg::*;
#(
  parameter bit TRAP_HALTS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       halted,
  output logic [3:0] state
);

  state_t state_reg;
  state_t state_next;
  ctrl_t  ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:     if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_RTYPE:     state_next = S_R_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDI_EXEC;
          default:      state_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  state_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_next = S_MEM_WB;
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_next = S_FETCH;
      S_R_EXEC:    state_next = S_R_WB;
      S_R_WB:      state_next = S_FETCH;
      S_BRANCH:    state_next = S_FETCH;
      S_JUMP:      state_next = S_FETCH;
      S_ADDI_EXEC: state_next = S_ADDI_WB;
      S_ADDI_WB:   state_next = S_FETCH;
      S_TRAP:      state_next = TRAP_HALTS ? S_TRAP : S_FETCH;
      default:     state_next = S_FETCH;
    endcase
  end

  mc_outputs u_outputs (
    .state     (state_reg),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Gate combinationally so enables drop the instant reset rises, not at the next edge.
  assign pc_en      = ctrl.pc_en     & ~reset;
  assign ir_write   = ctrl.ir_write  & ~reset;
  assign mem_read   = ctrl.mem_read  & ~reset;
  assign mem_write  = ctrl.mem_write & ~reset;
  assign reg_write  = ctrl.reg_write & ~reset;
  assign halted     = ctrl.halted    & ~reset;
  assign iord       = ctrl.iord;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign state      = state_reg;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: walks each instruction class through the
// FSM and compares state plus the packed control vector at every negedge.
module tb_mc_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, halted;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  mc_control #(.TRAP_HALTS(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .halted     (halted),
    .state      (state)
  );

  // {pc_en,iord,rd,wr,ir,dst,m2r,rw,srca,srcb[2],aluop[2],pcsrc[2],halted}
  logic [15:0] ctrl_obs;
  assign ctrl_obs = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                     reg_write, alu_src_a, alu_src_b, alu_op, pc_source, halted};

  localparam logic [15:0] V_RESET     = 16'b0_0_0_0_0_0_0_0_0_01_00_00_0;
  localparam logic [15:0] V_FETCH_RDY = 16'b1_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [15:0] V_FETCH_WT  = 16'b0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [15:0] V_DECODE    = 16'b0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [15:0] V_MEM_ADDR  = 16'b0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [15:0] V_MEM_READ  = 16'b0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [15:0] V_MEM_WB    = 16'b0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [15:0] V_MEM_WRITE = 16'b0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [15:0] V_R_EXEC    = 16'b0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [15:0] V_R_WB      = 16'b0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [15:0] V_BEQ_TAKEN = 16'b1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [15:0] V_BEQ_NOT   = 16'b0_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [15:0] V_JUMP      = 16'b1_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [15:0] V_ADDI_EXEC = 16'b0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [15:0] V_ADDI_WB   = 16'b0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [15:0] V_TRAP      = 16'b0_0_0_0_0_0_0_0_0_00_00_00_1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; checks at the following falling edge.
  task automatic cyc(input string tag, input logic [3:0] es, input logic [15:0] ec);
    @(negedge clk);
    $display("step %-14s state=%0d ctrl=%04h", tag, state, ctrl_obs);
    check({tag, "_state"}, {12'd0, state}, {12'd0, es});
    check({tag, "_ctrl"}, ctrl_obs, ec);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    cyc("reset", 4'd0, V_RESET);
    reset = 1'b0;

    // lw, no wait states: 0,1,2,3,4,0
    opcode = 6'h23;
    cyc("lw_fetch", 4'd0, V_FETCH_RDY);
    cyc("lw_decode", 4'd1, V_DECODE);
    cyc("lw_addr", 4'd2, V_MEM_ADDR);
    cyc("lw_read", 4'd3, V_MEM_READ);
    cyc("lw_wb", 4'd4, V_MEM_WB);

    // sw with a fetch stall and two write wait states
    opcode = 6'h2B; mem_ready = 1'b0;
    cyc("sw_fetch_wait", 4'd0, V_FETCH_WT);
    mem_ready = 1'b1;
    cyc("sw_fetch", 4'd0, V_FETCH_RDY);
    cyc("sw_decode", 4'd1, V_DECODE);
    cyc("sw_addr", 4'd2, V_MEM_ADDR);
    mem_ready = 1'b0;
    cyc("sw_write_w1", 4'd5, V_MEM_WRITE);
    cyc("sw_write_w2", 4'd5, V_MEM_WRITE);
    mem_ready = 1'b1;
    cyc("sw_write", 4'd5, V_MEM_WRITE);

    // beq taken, then not taken
    opcode = 6'h04; zero = 1'b1;
    cyc("beq1_fetch", 4'd0, V_FETCH_RDY);
    cyc("beq1_decode", 4'd1, V_DECODE);
    cyc("beq1_branch", 4'd8, V_BEQ_TAKEN);
    zero = 1'b0;
    cyc("beq0_fetch", 4'd0, V_FETCH_RDY);
    cyc("beq0_decode", 4'd1, V_DECODE);
    cyc("beq0_branch", 4'd8, V_BEQ_NOT);

    // j
    opcode = 6'h02;
    cyc("j_fetch", 4'd0, V_FETCH_RDY);
    cyc("j_decode", 4'd1, V_DECODE);
    cyc("j_jump", 4'd9, V_JUMP);

    // R-type; opcode garbage in R_EXEC must not matter
    opcode = 6'h00;
    cyc("r_fetch", 4'd0, V_FETCH_RDY);
    cyc("r_decode", 4'd1, V_DECODE);
    opcode = 6'h3F;
    cyc("r_exec", 4'd6, V_R_EXEC);
    cyc("r_wb", 4'd7, V_R_WB);

    // addi
    opcode = 6'h08;
    cyc("addi_fetch", 4'd0, V_FETCH_RDY);
    cyc("addi_decode", 4'd1, V_DECODE);
    cyc("addi_exec", 4'd10, V_ADDI_EXEC);
    cyc("addi_wb", 4'd11, V_ADDI_WB);

    // lw interrupted by reset while stalled in MEM_READ
    opcode = 6'h23;
    cyc("lwr_fetch", 4'd0, V_FETCH_RDY);
    cyc("lwr_decode", 4'd1, V_DECODE);
    cyc("lwr_addr", 4'd2, V_MEM_ADDR);
    mem_ready = 1'b0;
    cyc("lwr_read_wait", 4'd3, V_MEM_READ);
    #2;
    check("lwr_pre_reset_state", {12'd0, state}, 16'd3);
    reset = 1'b1;
    #1;
    check("lwr_async_state", {12'd0, state}, 16'd0);
    check("lwr_async_ctrl", ctrl_obs, V_RESET);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    cyc("lwr_in_reset", 4'd0, V_RESET);
    reset = 1'b0;
    cyc("lwr_refetch", 4'd0, V_FETCH_RDY);
    cyc("lwr_redecode", 4'd1, V_DECODE);
    cyc("lwr_readdr", 4'd2, V_MEM_ADDR);
    cyc("lwr_reread", 4'd3, V_MEM_READ);
    cyc("lwr_rewb", 4'd4, V_MEM_WB);

    // illegal opcode halts until reset
    opcode = 6'h3F;
    cyc("trap_fetch", 4'd0, V_FETCH_RDY);
    cyc("trap_decode", 4'd1, V_DECODE);
    cyc("trap_1", 4'd12, V_TRAP);
    opcode = 6'h00; mem_ready = 1'b0;
    cyc("trap_2", 4'd12, V_TRAP);
    mem_ready = 1'b1;
    cyc("trap_3", 4'd12, V_TRAP);
    reset = 1'b1;
    #1;
    check("trap_reset_state", {12'd0, state}, 16'd0);
    check("trap_reset_ctrl", ctrl_obs, V_RESET);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc("trap_refetch", 4'd0, V_FETCH_RDY);
    cyc("trap_redecode", 4'd1, V_DECODE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
